// File: rtl/ram64x8_pkg.sv
// Shared types and march-element tables for the 64x8 RAM March C- BIST.
package ram64x8_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef logic [2:0] elem_t;

  localparam elem_t EL_M0 = 3'd0;
  localparam elem_t EL_M1 = 3'd1;
  localparam elem_t EL_M2 = 3'd2;
  localparam elem_t EL_M3 = 3'd3;
  localparam elem_t EL_M4 = 3'd4;
  localparam elem_t EL_M5 = 3'd5;

  // Descending elements walk 63 -> 0.
  function automatic logic elem_down(input elem_t e);
    case (e)
      EL_M3, EL_M4, EL_M5: elem_down = 1'b1;
      default:             elem_down = 1'b0;
    endcase
  endfunction

  // 1 when the element expects to read the inverted background.
  function automatic logic elem_rd_one(input elem_t e);
    case (e)
      EL_M2, EL_M4: elem_rd_one = 1'b1;
      default:      elem_rd_one = 1'b0;
    endcase
  endfunction

  // 1 when the element writes the inverted background.
  function automatic logic elem_wr_one(input elem_t e);
    case (e)
      EL_M1, EL_M3: elem_wr_one = 1'b1;
      default:      elem_wr_one = 1'b0;
    endcase
  endfunction

  function automatic logic elem_has_wr(input elem_t e);
    case (e)
      EL_M0, EL_M1, EL_M2, EL_M3, EL_M4: elem_has_wr = 1'b1;
      default:                           elem_has_wr = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ram64x8_bist_addr_gen.sv
// Up/down address counter with load to either end and terminal-count flag.
module ram64x8_bist_addr_gen
  import ram64x8_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         load_top,
  input  logic         step,
  input  logic         down,
  output logic [W-1:0] addr,
  output logic         tc
);

  // Counter register; load has priority over step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= {W{1'b0}};
    end else if (load) begin
      addr <= load_top ? {W{1'b1}} : {W{1'b0}};
    end else if (step) begin
      addr <= down ? addr - {{(W-1){1'b0}}, 1'b1} : addr + {{(W-1){1'b0}}, 1'b1};
    end else begin
      addr <= addr;
    end
  end

  assign tc = down ? (addr == {W{1'b0}}) : (addr == {W{1'b1}});

endmodule

// File: rtl/ram64x8_march_bist.sv
// March C- BIST controller for the 64x8 single-port RAM, with functional
// pass-through while idle.
module ram64x8_march_bist #(
  parameter int              ADDR_W = 6,
  parameter int              DATA_W = 8,
  parameter logic [DATA_W-1:0] BG   = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] sys_data,
  input  logic [ADDR_W-1:0] sys_addr,
  input  logic              sys_we,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        fail_elem
);
  import ram64x8_pkg::*;

  state_t            state_r;
  elem_t             elem_r;
  logic              busy_r, done_r, pass_r, fail_r;
  logic [ADDR_W-1:0] fail_addr_r;
  logic [DATA_W-1:0] fail_data_r;
  elem_t             fail_elem_r;
  logic              bist_we_r;
  logic [DATA_W-1:0] bist_data_r;

  logic [ADDR_W-1:0] addr_s;
  logic              tc_s, down_s;
  logic              cnt_load_s, cnt_top_s, cnt_step_s;
  logic [DATA_W-1:0] exp_s, wr_s;
  logic              mismatch_s;
  elem_t             next_elem_s;

  assign down_s      = elem_down(elem_r);
  assign exp_s       = elem_rd_one(elem_r) ? ~BG : BG;
  assign wr_s        = elem_wr_one(elem_r) ? ~BG : BG;
  assign mismatch_s  = (ram_q != exp_s);
  assign next_elem_s = elem_r + 3'd1;

  ram64x8_bist_addr_gen #(.W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load_s),
    .load_top (cnt_top_s),
    .step     (cnt_step_s),
    .down     (down_s),
    .addr     (addr_s),
    .tc       (tc_s)
  );

  // Address counter control derived from the current state.
  always_comb begin
    cnt_load_s = 1'b0;
    cnt_top_s  = 1'b0;
    cnt_step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          cnt_load_s = 1'b1;
        end else begin
          cnt_load_s = 1'b0;
        end
      end
      ST_WR: begin
        if (tc_s) begin
          cnt_load_s = 1'b1;
        end else begin
          cnt_step_s = 1'b1;
        end
      end
      ST_CMP: begin
        if (mismatch_s) begin
          cnt_step_s = 1'b0;
        end else if (!tc_s) begin
          cnt_step_s = 1'b1;
        end else if (elem_r != EL_M5) begin
          cnt_load_s = 1'b1;
          cnt_top_s  = elem_down(next_elem_s);
        end else begin
          cnt_step_s = 1'b0;
        end
      end
      default: begin
        cnt_load_s = 1'b0;
      end
    endcase
  end

  // Sequencer, comparator result capture and registered BIST outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      elem_r      <= EL_M0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      fail_addr_r <= {ADDR_W{1'b0}};
      fail_data_r <= {DATA_W{1'b0}};
      fail_elem_r <= EL_M0;
      bist_we_r   <= 1'b0;
      bist_data_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r     <= ST_WR;
            elem_r      <= EL_M0;
            busy_r      <= 1'b1;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            fail_addr_r <= {ADDR_W{1'b0}};
            fail_data_r <= {DATA_W{1'b0}};
            fail_elem_r <= EL_M0;
            bist_we_r   <= 1'b1;
            bist_data_r <= BG;
          end
        end
        ST_WR: begin
          if (tc_s) begin
            state_r   <= ST_RD;
            elem_r    <= EL_M1;
            bist_we_r <= 1'b0;
          end
        end
        ST_RD: begin
          state_r     <= ST_CMP;
          bist_we_r   <= elem_has_wr(elem_r);
          bist_data_r <= wr_s;
        end
        ST_CMP: begin
          bist_we_r <= 1'b0;
          if (mismatch_s) begin
            fail_r      <= 1'b1;
            fail_addr_r <= addr_s;
            fail_data_r <= ram_q;
            fail_elem_r <= elem_r;
            state_r     <= ST_DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end else if (!tc_s) begin
            state_r <= ST_RD;
          end else if (elem_r == EL_M5) begin
            pass_r  <= 1'b1;
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            elem_r  <= next_elem_s;
            state_r <= ST_RD;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          bist_we_r <= 1'b0;
        end
      endcase
    end
  end

  // The RAM belongs to the functional port whenever no test is running.
  assign ram_we    = busy_r ? bist_we_r   : sys_we;
  assign ram_addr  = busy_r ? addr_s      : sys_addr;
  assign ram_data  = busy_r ? bist_data_r : sys_data;

  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail      = fail_r;
  assign fail_addr = fail_addr_r;
  assign fail_data = fail_data_r;
  assign fail_elem = fail_elem_r;

endmodule
